scan_cfg_loader: RTL and testbench

- Upstream configuration stage for the fabric's scan-configured routing blocks: vertical_channel, horizontal_channel and later CLBs.
- Accepts a configuration bitstream as WORD_W-bit words over a valid/ready stream.
- Serializes each load MSB-first onto one scan chain of CHAIN_LEN bits, gating scan_en exactly per shifted bit.
- Captures the previous chain contents arriving on scan_out and returns them as readback words.

---
 rtl/scan_cfg_loader.sv | 146 ++++++++++++++
 tb/tb_scan_cfg_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_cfg_loader.sv
// Scan-chain configuration loader: streams host words MSB-first into one scan chain
// and returns the chain's previous contents as readback words.
module scan_cfg_loader #(
    parameter int unsigned CHAIN_LEN = 8,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              scan_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done
);
    localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WbW  = $clog2(WORD_W + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WbW-1:0]    word_bits_q, word_bits_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [WbW-1:0]    rb_idx_q, rb_idx_d;
    logic [WORD_W-1:0] rb_word_q, rb_word_d;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic [CntW-1:0]   remaining;
    logic [WbW-1:0]    take_bits;
    logic [WORD_W-1:0] rb_bit, rb_cur;

    // Outputs are decoded from registered state only, so reset clears them at once.
    assign cfg_ready = (state_q == StFetch) && !abort;
    assign scan_en   = (state_q == StShift);
    assign scan_in   = (state_q == StShift) && sreg_q[WORD_W-1];
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rb_valid  = rb_valid_q;
    assign rb_data   = rb_data_q;

    always_comb begin
        remaining = CntW'(CHAIN_LEN) - bit_cnt_q;
        if (32'(remaining) >= WORD_W) begin
            take_bits = WbW'(WORD_W);
        end else begin
            take_bits = WbW'(remaining);
        end
    end

    // Readback bits fill from the MSB down so a short final word ends up left-aligned.
    always_comb begin
        rb_bit             = '0;
        rb_bit[WORD_W-1]   = scan_out;
        rb_cur             = rb_word_q | (rb_bit >> rb_idx_q);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_bits_d = word_bits_q;
        sreg_d      = sreg_q;
        rb_idx_d    = rb_idx_q;
        rb_word_d   = rb_word_q;
        rb_valid_d  = 1'b0;
        rb_data_d   = rb_data_q;

        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            bit_cnt_d   = '0;
            word_bits_d = '0;
            sreg_d      = '0;
            rb_idx_d    = '0;
            rb_word_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bit_cnt_d = '0;
                    if (start && !abort) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (cfg_valid) begin
                        sreg_d      = cfg_data;
                        word_bits_d = take_bits;
                        state_d     = StShift;
                    end
                end
                StShift: begin
                    sreg_d      = sreg_q << 1;
                    bit_cnt_d   = bit_cnt_q + CntW'(1);
                    word_bits_d = word_bits_q - WbW'(1);
                    if (word_bits_q == WbW'(1)) begin
                        rb_valid_d = 1'b1;
                        rb_data_d  = rb_cur;
                        rb_word_d  = '0;
                        rb_idx_d   = '0;
                        state_d    = (bit_cnt_d == CntW'(CHAIN_LEN)) ? StDone : StFetch;
                    end else begin
                        rb_word_d = rb_cur;
                        rb_idx_d  = rb_idx_q + WbW'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            word_bits_q <= '0;
            sreg_q      <= '0;
            rb_idx_q    <= '0;
            rb_word_q   <= '0;
            rb_valid_q  <= 1'b0;
            rb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_bits_q <= word_bits_d;
            sreg_q      <= sreg_d;
            rb_idx_q    <= rb_idx_d;
            rb_word_q   <= rb_word_d;
            rb_valid_q  <= rb_valid_d;
            rb_data_q   <= rb_data_d;
        end
    end

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Bench for scan_cfg_loader: three geometries (4/2, 8/8, 5/4), each with a behavioural chain.
module tb_scan_cfg_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       abort = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;

    logic       rdy0, en0, sin0, sout0, rbv0, bsy0, dn0;
    logic [1:0] rbd0;
    logic       rdy1, en1, sin1, sout1, rbv1, bsy1, dn1;
    logic [7:0] rbd1;
    logic       rdy2, en2, sin2, sout2, rbv2, bsy2, dn2;
    logic [3:0] rbd2;

    logic [7:0] chain [3] = '{default: 8'h00};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_cfg_loader #(.CHAIN_LEN(4), .WORD_W(2)) u0 (
        .scan_clk(clk), .rst_n(rst_n), .start(st0), .abort(abort), .cfg_valid(cfg_valid),
        .cfg_ready(rdy0), .cfg_data(cfg_data[1:0]), .scan_en(en0), .scan_in(sin0),
        .scan_out(sout0), .rb_valid(rbv0), .rb_data(rbd0), .busy(bsy0), .done(dn0)
    );
    scan_cfg_loader #(.CHAIN_LEN(8), .WORD_W(8)) u1 (
        .scan_clk(clk), .rst_n(rst_n), .start(st1), .abort(abort), .cfg_valid(cfg_valid),
        .cfg_ready(rdy1), .cfg_data(cfg_data), .scan_en(en1), .scan_in(sin1),
        .scan_out(sout1), .rb_valid(rbv1), .rb_data(rbd1), .busy(bsy1), .done(dn1)
    );
    scan_cfg_loader #(.CHAIN_LEN(5), .WORD_W(4)) u2 (
        .scan_clk(clk), .rst_n(rst_n), .start(st2), .abort(abort), .cfg_valid(cfg_valid),
        .cfg_ready(rdy2), .cfg_data(cfg_data[3:0]), .scan_en(en2), .scan_in(sin2),
        .scan_out(sout2), .rb_valid(rbv2), .rb_data(rbd2), .busy(bsy2), .done(dn2)
    );

    // Fabric stand-in: bit 0 is the chain head, bit LEN-1 drives scan_out.
    assign sout0 = chain[0][3];
    assign sout1 = chain[1][7];
    assign sout2 = chain[2][4];

    always @(posedge clk) begin
        if (en0) chain[0] <= {chain[0][6:0], sin0};
        if (en1) chain[1] <= {chain[1][6:0], sin1};
        if (en2) chain[2] <= {chain[2][6:0], sin2};
    end

    function automatic int cl(input int s);
        case (s) 0: return 4; 1: return 8; default: return 5; endcase
    endfunction
    function automatic int ww(input int s);
        case (s) 0: return 2; 1: return 8; default: return 4; endcase
    endfunction
    function automatic logic g_en(input int s);
        case (s) 0: return en0; 1: return en1; default: return en2; endcase
    endfunction
    function automatic logic g_in(input int s);
        case (s) 0: return sin0; 1: return sin1; default: return sin2; endcase
    endfunction
    function automatic logic g_rdy(input int s);
        case (s) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic g_rbv(input int s);
        case (s) 0: return rbv0; 1: return rbv1; default: return rbv2; endcase
    endfunction
    function automatic logic g_bsy(input int s);
        case (s) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
    endfunction
    function automatic logic g_dn(input int s);
        case (s) 0: return dn0; 1: return dn1; default: return dn2; endcase
    endfunction
    function automatic logic [7:0] g_rbd(input int s);
        case (s) 0: return {6'b0, rbd0}; 1: return rbd1; default: return {4'b0, rbd2}; endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s) 0: st0 = v; 1: st1 = v; default: st2 = v; endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Stimulus words / per-word valid gaps, observations and expectations.
    logic [7:0] wq[$];
    int         gq[$];
    bit         obs_bits[$];
    logic [7:0] obs_rb[$];
    int         obs_done, obs_lat, obs_en_pre;
    bit         obs_timeout;
    bit         exp_bits[$];
    logic [7:0] exp_rb[$];
    int         exp_done, exp_lat;

    task automatic run_load(input int s, input int abort_at, input int xstart);
        int  wi, gap_left, shifted, cyc, first_hs;
        bit  abort_used;
        obs_bits.delete();
        obs_rb.delete();
        obs_done = 0; obs_lat = -1; obs_en_pre = 0; obs_timeout = 1'b0;
        wi = 0; shifted = 0; cyc = 0; first_hs = -1; abort_used = 1'b0;
        gap_left = (gq.size() > 0) ? gq[0] : 0;
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        forever begin
            if (g_en(s)) begin
                obs_bits.push_back(g_in(s));
                shifted++;
                if (first_hs < 0) obs_en_pre++;
            end
            if (g_rbv(s)) obs_rb.push_back(g_rbd(s));
            if (g_dn(s)) begin
                obs_done++;
                if (first_hs >= 0) obs_lat = cyc - first_hs;
            end
            if (!g_bsy(s)) break;
            if (cyc >= 200) begin
                obs_timeout = 1'b1;
                break;
            end
            abort = (abort_at >= 0) && !abort_used && (shifted == abort_at);
            if (abort) abort_used = 1'b1;
            set_start(s, cyc == xstart);
            if (wi < wq.size() && gap_left == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = wq[wi];
            end else begin
                cfg_valid = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            #1;
            if (abort) check("abort_blocks_ready", 32'(g_rdy(s)), 0);
            if (cfg_valid && g_rdy(s)) begin
                if (first_hs < 0) first_hs = cyc;
                wi++;
                gap_left = (wi < gq.size()) ? gq[wi] : 0;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        cfg_valid = 1'b0;
        set_start(s, 1'b0);
    endtask

    // Reference: bitstream is the first L bits of the words MSB-first; readback is the old
    // chain read tail-first in W-bit chunks; timing is one fetch cycle plus b shift cycles/word.
    task automatic model(input int s, input logic [7:0] old_chain);
        int L, W, nw, t, prev_bits, b;
        logic [7:0] w, r;
        L = cl(s); W = ww(s); nw = (L + W - 1) / W;
        exp_bits.delete();
        exp_rb.delete();
        for (int k = 0; k < L; k++) begin
            w = wq[k / W];
            exp_bits.push_back(w[W - 1 - (k % W)]);
        end
        for (int k = 0; k < nw; k++) begin
            r = 8'h00;
            for (int j = 0; j < W; j++) begin
                if (k * W + j < L) r[W - 1 - j] = old_chain[L - 1 - (k * W + j)];
            end
            exp_rb.push_back(r);
        end
        t = 0; prev_bits = 0;
        for (int k = 0; k < nw; k++) begin
            b = (L - k * W < W) ? L - k * W : W;
            if (k > 0) t = (gq[k] > prev_bits) ? t + 1 + gq[k] : t + 1 + prev_bits;
            prev_bits = b;
        end
        exp_lat  = t + 1 + prev_bits;
        exp_done = 1;
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] op, ep;
        check({tag, ".timeout"}, 32'(obs_timeout), 0);
        check({tag, ".en_before_hs"}, obs_en_pre, 0);
        check({tag, ".nbits"}, obs_bits.size(), exp_bits.size());
        op = 8'h00; ep = 8'h00;
        foreach (obs_bits[i]) op = {op[6:0], obs_bits[i]};
        foreach (exp_bits[i]) ep = {ep[6:0], exp_bits[i]};
        check({tag, ".scan_bits"}, 32'(op), 32'(ep));
        check({tag, ".n_rb"}, obs_rb.size(), exp_rb.size());
        for (int i = 0; i < obs_rb.size() && i < exp_rb.size(); i++) begin
            check($sformatf("%s.rb%0d", tag, i), 32'(obs_rb[i]), 32'(exp_rb[i]));
        end
        check({tag, ".n_done"}, obs_done, exp_done);
        if (exp_lat >= 0) check({tag, ".latency"}, obs_lat, exp_lat);
    endtask

    task automatic check_chain(input string tag, input int s);
        logic [7:0] ec, mask;
        int L;
        L = cl(s);
        ec = 8'h00;
        foreach (exp_bits[k]) ec[L - 1 - k] = exp_bits[k];
        mask = 8'hFF >> (8 - L);
        check({tag, ".chain"}, 32'(chain[s] & mask), 32'(ec));
    endtask

    typedef struct {
        int         s;
        logic [7:0] w0, w1;
        int         nw, lead, abort_at, xstart;
        int         nbits;
        logic [7:0] bits;
        int         ndone, lat, nrb;
        logic [7:0] rb0, rb1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] old;
        int s, nw;

        tbl[0] = '{0, 8'h2,  8'h1, 2, 0, -1, -1, 4, 8'h09, 1,  6, 2, 8'h0, 8'h0};
        tbl[1] = '{0, 8'h3,  8'h0, 2, 0, -1, -1, 4, 8'h0C, 1,  6, 2, 8'h2, 8'h1};
        tbl[2] = '{1, 8'hA5, 8'h0, 1, 3, -1, -1, 8, 8'hA5, 1,  9, 1, 8'h0, 8'h0};
        tbl[3] = '{2, 8'hF,  8'h8, 2, 0, -1, -1, 5, 8'h1F, 1,  7, 2, 8'h0, 8'h0};
        tbl[4] = '{2, 8'h0,  8'h3, 2, 0, -1, -1, 5, 8'h00, 1,  7, 2, 8'hF, 8'h8};
        tbl[5] = '{0, 8'h1,  8'h2, 2, 0,  2, -1, 2, 8'h01, 0, -1, 0, 8'h0, 8'h0};
        tbl[6] = '{0, 8'h3,  8'h1, 2, 0, -1, -1, 4, 8'h0D, 1,  6, 2, 8'h0, 8'h1};
        tbl[7] = '{1, 8'h3C, 8'h0, 1, 0,  0, -1, 0, 8'h00, 0, -1, 0, 8'h0, 8'h0};
        tbl[8] = '{2, 8'hA,  8'h5, 2, 0, -1,  2, 5, 8'h14, 1,  7, 2, 8'h0, 8'h0};

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst.cfg_ready", 32'(rdy0), 0);
        check("rst.scan_en",   32'(en0),  0);
        check("rst.scan_in",   32'(sin0), 0);
        check("rst.rb_valid",  32'(rbv0), 0);
        check("rst.rb_data",   32'(rbd1), 0);
        check("rst.busy",      32'(bsy2), 0);
        check("rst.done",      32'(dn1),  0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            wq.delete(); gq.delete();
            wq.push_back(tbl[i].w0); gq.push_back(tbl[i].lead);
            if (tbl[i].nw > 1) begin
                wq.push_back(tbl[i].w1); gq.push_back(0);
            end
            exp_bits.delete(); exp_rb.delete();
            for (int k = 0; k < tbl[i].nbits; k++) exp_bits.push_back(tbl[i].bits[tbl[i].nbits-1-k]);
            if (tbl[i].nrb > 0) exp_rb.push_back(tbl[i].rb0);
            if (tbl[i].nrb > 1) exp_rb.push_back(tbl[i].rb1);
            exp_done = tbl[i].ndone;
            exp_lat  = tbl[i].lat;
            run_load(tbl[i].s, tbl[i].abort_at, tbl[i].xstart);
            compare_all($sformatf("tbl%0d", i));
            if (tbl[i].abort_at < 0) check_chain($sformatf("tbl%0d", i), tbl[i].s);
        end

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'h02;
        @(negedge clk);
        check("arst.shifting", 32'(en0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.scan_en",   32'(en0),  0);
        check("arst.busy",      32'(bsy0), 0);
        check("arst.cfg_ready", 32'(rdy0), 0);
        check("arst.scan_in",   32'(sin0), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised loads against the reference model
        for (int i = 0; i < 30; i++) begin
            s  = int'($urandom_range(0, 2));
            nw = (cl(s) + ww(s) - 1) / ww(s);
            wq.delete(); gq.delete();
            for (int k = 0; k < nw; k++) begin
                wq.push_back(8'($urandom) & (8'hFF >> (8 - ww(s))));
                gq.push_back(int'($urandom_range(0, 3)));
            end
            old = chain[s];
            model(s, old);
            run_load(s, -1, (i % 4 == 0) ? 1 : -1);
            compare_all($sformatf("rnd%0d", i));
            check_chain($sformatf("rnd%0d", i), s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
